// File: rtl/imem_prog.sv
// Synchronous-read instruction memory: clears itself to NOP after reset, loads programs through a word-write port, 1-cycle fetch with stall hold.
// Build option IMEM_FAULT_EN: flags misaligned and out-of-range fetches and returns NOP for them.
module imem_prog #(
  parameter int          DEPTH = 64,
  parameter int          AW    = $clog2(DEPTH),
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ready,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic [1:0]  fetch_fault,
  input  logic        stall,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_data,
  output logic        busy
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] clr_idx;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] fetch_idx, prog_idx;
  logic          accept, misaligned, out_of_range, prog_wr;
  logic [31:0]   rd_word;
  logic          unused_prog_bits;

  assign fetch_idx        = fetch_addr[AW+1:2];
  assign prog_idx         = prog_addr[AW+1:2];
  assign unused_prog_bits = ^{prog_addr[31:AW+2], prog_addr[1:0]};

`ifdef IMEM_FAULT_EN
  assign misaligned   = |fetch_addr[1:0];
  assign out_of_range = |fetch_addr[31:AW+2];
`else
  logic unused_fetch_bits;
  assign unused_fetch_bits = ^{fetch_addr[31:AW+2], fetch_addr[1:0]};
  assign misaligned        = 1'b0;
  assign out_of_range      = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    fetch_ready = 1'b0;
    case (state)
      CLEAR: begin
        busy = 1'b1;
        if (clr_idx == AW'(DEPTH - 1)) state_nxt = RUN;
      end
      RUN: fetch_ready = !(fetch_valid && stall);
      default: state_nxt = CLEAR;
    endcase
  end

  assign accept  = fetch_req && fetch_ready;
  assign prog_wr = prog_we && (state == RUN);

  // Same-word write and fetch in one cycle: the fetch sees the new data.
  assign rd_word = (prog_wr && (prog_idx == fetch_idx)) ? prog_data : mem[fetch_idx];

  // Array has no reset; the sweep rewrites every word once reset releases.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) mem[clr_idx] <= NOP;
      else if (prog_wr)   mem[prog_idx] <= prog_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_valid <= 1'b0;
      fetch_instr <= NOP;
      fetch_fault <= 2'b00;
    end else if (accept) begin
      fetch_valid <= 1'b1;
      fetch_instr <= (misaligned || out_of_range) ? NOP : rd_word;
      fetch_fault <= {out_of_range, misaligned};
    end else if (!(fetch_valid && stall)) begin
      fetch_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_prog.sv
// Randomized scoreboard bench for imem_prog against an array-based reference model.
module tb_imem_prog;
  localparam int          DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [1:0]  fault;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req, fetch_ready, fetch_valid, stall, prog_we, busy;
  logic [31:0] fetch_addr, fetch_instr, prog_addr, prog_data;
  logic [1:0]  fetch_fault;

  always #5 clk = ~clk;

  imem_prog #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_fault(fetch_fault),
    .stall(stall), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .busy(busy)
  );

  int          vectors = 0;
  int          miscompares = 0;
  resp_t       q[$];
  resp_t       last_exp;
  logic [31:0] mem_m [DEPTH];
  bit          model_run = 1'b0;
  bit          pend_acc = 1'b0;
  bit          held = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: word index = byte address / 4 modulo DEPTH; write-first on same word.
  function automatic resp_t model_fetch(input logic [31:0] a, input bit we,
                                        input logic [31:0] wa, input logic [31:0] wd);
    resp_t       r;
    int unsigned idx;
    bit          mis, rng;
    idx = (a / 4) % DEPTH;
    mis = (a % 4) != 0;
    rng = a >= 32'(4 * DEPTH);
    r.instr = (we && ((wa / 4) % DEPTH) == idx) ? wd : mem_m[idx];
    r.fault = 2'b00;
`ifdef IMEM_FAULT_EN
    if (mis || rng) begin
      r.instr = NOP;
      r.fault = {rng, mis};
    end
`else
    if (mis && rng) r.fault = 2'b00;
`endif
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      pend_acc = 1'b0;
      held     = 1'b0;
      last_exp = {NOP, 2'b00};
    end else begin
      if (pend_acc) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL resp_unexpected: response with empty scoreboard (t=%0t)", $time);
        end else begin
          last_exp = q.pop_front();
          chk("resp_valid", 32'(fetch_valid), 32'd1);
          chk("resp_instr", fetch_instr, last_exp.instr);
          chk("resp_fault", 32'(fetch_fault), 32'(last_exp.fault));
        end
      end else if (held) begin
        chk("hold_valid", 32'(fetch_valid), 32'd1);
        chk("hold_instr", fetch_instr, last_exp.instr);
        chk("hold_fault", 32'(fetch_fault), 32'(last_exp.fault));
      end else begin
        chk("idle_valid", 32'(fetch_valid), 32'd0);
        chk("idle_instr", fetch_instr, last_exp.instr);
        chk("idle_fault", 32'(fetch_fault), 32'(last_exp.fault));
      end
      pend_acc = fetch_req && fetch_ready;
      held     = fetch_valid && stall;
    end
  end

  task automatic issue(input bit req, input logic [31:0] addr, input bit stl, input bit we,
                       input logic [31:0] waddr, input logic [31:0] wdata, output bit acc);
    fetch_req  = req;
    fetch_addr = addr;
    stall      = stl;
    prog_we    = we;
    prog_addr  = waddr;
    prog_data  = wdata;
    @(negedge clk);
    acc = req && fetch_ready;
    if (acc) q.push_back(model_fetch(addr, we && model_run, waddr, wdata));
    if (we && model_run) mem_m[(waddr / 4) % DEPTH] = wdata;
    @(posedge clk);
    #1;
    fetch_req = 1'b0;
    prog_we   = 1'b0;
    stall     = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    bit acc;
    int n = 0;
    do begin
      issue(1'b1, a, 1'b0, 1'b0, 32'd0, 32'd0, acc);
      n++;
    end while (!acc && n < 20);
    chk("fetch_accept", 32'(acc), 32'd1);
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] d);
    bit acc;
    issue(1'b0, 32'd0, 1'b0, 1'b1, a, d, acc);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},  32'(busy), 32'd1);
    chk({tag, "_ready"}, 32'(fetch_ready), 32'd0);
    chk({tag, "_valid"}, 32'(fetch_valid), 32'd0);
    chk({tag, "_instr"}, fetch_instr, NOP);
    chk({tag, "_fault"}, 32'(fetch_fault), 32'd0);
  endtask

  task automatic do_reset(input int midpoint, input bit we_in_clear);
    bit acc;
    int n = 0;
    issue(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, acc);
    rst = 1'b1;
    model_run = 1'b0;
    #1;
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    if (midpoint > 0) begin
      repeat (midpoint) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      @(posedge clk);
      #1;
      rst = 1'b0;
    end
    prog_we   = we_in_clear;
    prog_addr = 32'h18;
    prog_data = 32'h1234_5678;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == DEPTH - 1) chk("ready_before_sweep_end", 32'(fetch_ready), 32'd0);
    end while (busy && n < 200);
    prog_we = 1'b0;
    chk("sweep_edges", 32'(n), 32'(DEPTH));
    chk("ready_after_sweep", 32'(fetch_ready), 32'd1);
    for (int i = 0; i < DEPTH; i++) mem_m[i] = NOP;
    model_run = 1'b1;
  endtask

  initial begin
    bit          acc, req, we, stl;
    logic [31:0] a, wa;
    int          r;
    rst = 1'b1;
    fetch_req = 1'b0; fetch_addr = '0; stall = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset(0, 1'b0);

    fetch(32'h00); fetch(32'h7C); fetch(32'hFC);
    write(32'h00, 32'h7FF0_0F13);
    write(32'h04, 32'h00D0_0E13);
    fetch(32'h00); fetch(32'h04);

    // Stall: response to 0x04 held for three cycles, pending request waits.
    fetch(32'h04);
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 32'h00, 1'b1, 1'b0, 32'd0, 32'd0, acc);
      chk("stall_no_accept", 32'(acc), 32'd0);
    end
    issue(1'b1, 32'h00, 1'b0, 1'b0, 32'd0, 32'd0, acc);
    chk("accept_after_stall", 32'(acc), 32'd1);

    issue(1'b1, 32'h18, 1'b0, 1'b1, 32'h18, 32'hFF5F_F06F, acc);
    chk("collision_accept", 32'(acc), 32'd1);

    fetch(32'h06); fetch(32'h100); fetch(32'h102); fetch(32'h18);

    for (int i = 0; i < 400; i++) begin
      r   = $urandom_range(0, 9);
      req = $urandom_range(0, 3) != 0;
      if (r < 7)       a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      else if (r == 7) a = 32'($urandom_range(0, 4 * DEPTH - 1));
      else if (r == 8) a = $urandom();
      else             a = 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
      we  = $urandom_range(0, 3) == 0;
      wa  = ($urandom_range(0, 1) == 0) ? a : $urandom();
      stl = $urandom_range(0, 3) == 0;
      issue(req, a, stl, we, wa, $urandom(), acc);
    end

    // Reset mid-sweep with writes presented during CLEAR: writes must be dropped.
    do_reset(20, 1'b1);
    fetch(32'h18); fetch(32'h00); fetch(32'h04);

    repeat (3) issue(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, acc);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_prog.md
# imem_prog

Parametrised, synchronous-read instruction memory for the RV32I pipeline core. It replaces the fixed 64-word combinational ROM with a `DEPTH`-word array. After reset it clears itself to NOPs. Programs are loaded at run time through a word-write port, and the fetch stage reads it over a one-cycle valid/ready interface that supports stalls. Optionally, it flags misaligned and out-of-range fetches.

## Interface
Parameters:
- `DEPTH`, 64: number of 32-bit words; must be a power of two, at least 4.
- `AW`, $clog2(DEPTH): word-index width, derived; do not override.
- `NOP`, 32'h00000013: fill word used after reset and on faults (`addi x0,x0,0`).

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `fetch_req` in 1: fetch request.
- `fetch_addr` in 32: byte address of the fetch.
- `fetch_ready` out 1: request can be accepted this cycle.
- `fetch_valid` out 1: `fetch_instr` and `fetch_fault` are valid.
- `fetch_instr` out 32: fetched instruction word.
- `fetch_fault` out 2: 00 ok, 01 misaligned, 10 out of range, 11 both.
- `stall` in 1: downstream holds the current response.
- `prog_we` in 1: program-write strobe.
- `prog_addr` in 32: byte address of the write; bits [1:0] are ignored.
- `prog_data` in 32: write data.
- `busy` out 1: clear sweep in progress.

## Operation
- FSM states:
  - CLEAR is the reset state. A counter `clr_idx` runs from 0 to DEPTH-1 and writes `NOP` to `RAM[clr_idx]` on each edge. On the edge that writes DEPTH-1, the FSM moves to RUN.
  - RUN has no exit except `reset`.
- `busy` = (state==CLEAR). `fetch_ready` = (state==RUN) && !(fetch_valid && stall).
- Accept condition: `fetch_req && fetch_ready`. On acceptance, the registered response loads on the same edge:
  - `fetch_valid` is set to 1.
  - `fetch_instr` = `RAM[fetch_addr[AW+1:2]]`, or `NOP` if any fault bit is set.
  - `fetch_fault` = {range, misaligned}.
- Fault conditions:
  - misaligned = `fetch_addr[1:0]` != 0.
  - range = `fetch_addr[31:AW+2]` != 0.
- Edge with no acceptance:
  - If `fetch_valid && stall`, all response outputs hold.
  - Otherwise `fetch_valid` is 0 and `fetch_instr`/`fetch_fault` hold their last values.
- Program write:
  - In RUN, `prog_we` writes `prog_data` to `RAM[prog_addr[AW+1:2]]`.
  - Upper address bits are ignored; the write wraps modulo DEPTH.
  - `prog_we` in CLEAR is ignored and dropped, not queued.
- Write/read collision: a write and an accepted fetch to the same word in the same cycle is write-first. The response carries `prog_data`.
- `stall` with `fetch_valid`=0 has no effect.

## Timing
- Reset values (asserted asynchronously):
  - state CLEAR, `clr_idx` 0, `busy` 1.
  - `fetch_ready` 0, `fetch_valid` 0.
  - `fetch_instr` `NOP`, `fetch_fault` 00.
- Clear sweep: exactly DEPTH rising edges after reset deassertion. `fetch_ready` and `!busy` are first visible in the cycle after edge DEPTH.
- Fetch latency: 1 cycle, from the accepting edge to `fetch_valid`. Back-to-back accepts give one response per cycle.
- Stall: the response is held for every cycle `stall` is high. The next request is accepted on the first edge with `stall` low; that cycle's `fetch_ready` is already 1.
- Program write is visible to a fetch accepted on the same edge (write-first) and on every later edge.
- Reset mid-sweep or mid-fetch: outputs return to their reset values immediately and the sweep restarts from index 0. The RAM contents are not cleared asynchronously.

## Configuration
- `IMEM_FAULT_EN` defined:
  - Fault detection as described above.
  - Faulting fetches return `NOP` with `fetch_fault` set.
- `IMEM_FAULT_EN` undefined:
  - `fetch_fault` is tied to 00.
  - `fetch_addr[1:0]` is ignored and upper bits wrap modulo DEPTH.
  - The addressed word is always returned.

## Test plan
- Reset, then count edges (DEPTH=64) -> `busy` falls and `fetch_ready` rises after exactly 64 edges; fetches of 0x00, 0x7C and 0xFC all return 0x00000013 with fault 00.
- Write 0x7FF00F13 to 0x00 and 0x00D00E13 to 0x04, then back-to-back fetches of 0x00 and 0x04 -> valid on consecutive cycles with those words, 1-cycle latency each.
- Fetch 0x04 with `stall` high for 3 cycles -> `fetch_instr` holds 0x00D00E13 and `fetch_ready` is 0 for 3 cycles; a request presented during the stall is accepted on the first edge after `stall` drops.
- Same-cycle `prog_we` of 0xFF5FF06F to 0x18 and accepted fetch of 0x18 -> response is 0xFF5FF06F.
- With `IMEM_FAULT_EN`:
  - Fetch 0x06 -> fault 01, `NOP`.
  - Fetch 0x100 (DEPTH=64) -> fault 10, `NOP`.
  - Fetch 0x102 -> fault 11.
- Without `IMEM_FAULT_EN`: fetch 0x100 -> returns the word at 0x00, fault 00.
- Assert `reset` at sweep index 20, release, and assert `prog_we` during CLEAR -> sweep restarts and takes 64 edges, the write is dropped, and the target word reads `NOP`.
